ffo_scan_seq: RTL and testbench

FFO_SCAN_SEQ -- requirements
Module: ffo_scan_seq

---
 rtl/ffo_scan_seq.sv | 139 +++++++++++++
 tb/tb_ffo_scan_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffo_scan_seq.sv
// Sequential find-first-one scanner: walks a captured vector STEP bits per cycle
// in either direction and reports each set bit in turn as a held HIT.
module ffo_scan_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       dir,
   input  logic [WIDTH-1:0]           din,
   input  logic                       next,
   input  logic                       abort,
   output logic                       ready,
   output logic                       valid,
   output logic                       found,
   output logic [$clog2(WIDTH)-1:0]   pos,
   output logic [$clog2(WIDTH+1)-1:0] hit_count
);

   localparam int unsigned PW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] data;
   logic             dir_q;
   logic [PW-1:0]    cursor;

   logic hit_any;
   logic last_win;
   int   hit_l;
   int   hit_p;
   int   lp;
   int   ph;

   // Window search: lowest set logical position in cursor..cursor+STEP-1.
   always_comb begin
      hit_any  = 1'b0;
      hit_l    = int'(cursor);
      hit_p    = 0;
      lp       = 0;
      ph       = 0;
      last_win = (int'(cursor) + int'(STEP)) >= int'(WIDTH);
      for (int i = 0; i < int'(STEP); i++) begin
         lp = int'(cursor) + i;
         if (!hit_any && lp < int'(WIDTH)) begin
            ph = dir_q ? (int'(WIDTH) - 1 - lp) : lp;
            if (data[PW'(ph)]) begin
               hit_any = 1'b1;
               hit_l   = lp;
               hit_p   = ph;
            end
         end
      end
   end

   // Captured operands are reloaded on every accepted start, so they carry no reset.
   always_ff @(posedge clock) begin
      if (state == IDLE && start && !reset) begin
         data  <= din;
         dir_q <= dir;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cursor    <= '0;
         ready     <= 1'b1;
         valid     <= 1'b0;
         found     <= 1'b0;
         pos       <= '0;
         hit_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  cursor    <= '0;
                  hit_count <= '0;
                  ready     <= 1'b0;
               end
            end
            SCAN: begin
               if (abort) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end else if (hit_any) begin
                  state  <= HIT;
                  cursor <= PW'(hit_l);
                  valid  <= 1'b1;
                  found  <= 1'b1;
                  pos    <= PW'(hit_p);
                  if (hit_count != CW'(WIDTH)) hit_count <= hit_count + CW'(1);
               end else if (last_win) begin
                  state <= DONE;
                  valid <= 1'b1;
               end else begin
                  cursor <= cursor + PW'(STEP);
               end
            end
            HIT: begin
               if (abort) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  valid <= 1'b0;
                  found <= 1'b0;
                  pos   <= '0;
               end else if (next) begin
                  found <= 1'b0;
                  pos   <= '0;
                  if (cursor == PW'(WIDTH - 1)) begin
                     state <= DONE;
                  end else begin
                     state  <= SCAN;
                     cursor <= cursor + PW'(1);
                     valid  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b1;
               valid <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               valid <= 1'b0;
               found <= 1'b0;
               pos   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ffo_scan_seq.sv
// Bench for ffo_scan_seq: three configurations checked against a hit-list and
// latency model derived from the scan rules.
module tb_ffo_scan_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_v [3];
   logic        dir_v   [3];
   logic        next_v  [3];
   logic        abort_v [3];
   logic [31:0] din_v   [3];
   logic        ready_v [3];
   logic        valid_v [3];
   logic        found_v [3];
   logic [31:0] pos_v   [3];
   logic [31:0] hc_v    [3];

   logic [4:0] pos0, pos1;
   logic [5:0] hc0, hc1;
   logic [2:0] pos2, hc2;

   int wv [3] = '{32, 32, 5};
   int sv [3] = '{1, 4, 2};
   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   ffo_scan_seq #(.WIDTH(32), .STEP(1)) u_s1 (
      .clock(clock), .reset(reset), .start(start_v[0]), .dir(dir_v[0]), .din(din_v[0]),
      .next(next_v[0]), .abort(abort_v[0]), .ready(ready_v[0]), .valid(valid_v[0]),
      .found(found_v[0]), .pos(pos0), .hit_count(hc0));
   ffo_scan_seq #(.WIDTH(32), .STEP(4)) u_s4 (
      .clock(clock), .reset(reset), .start(start_v[1]), .dir(dir_v[1]), .din(din_v[1]),
      .next(next_v[1]), .abort(abort_v[1]), .ready(ready_v[1]), .valid(valid_v[1]),
      .found(found_v[1]), .pos(pos1), .hit_count(hc1));
   ffo_scan_seq #(.WIDTH(5), .STEP(2)) u_w5 (
      .clock(clock), .reset(reset), .start(start_v[2]), .dir(dir_v[2]), .din(din_v[2][4:0]),
      .next(next_v[2]), .abort(abort_v[2]), .ready(ready_v[2]), .valid(valid_v[2]),
      .found(found_v[2]), .pos(pos2), .hit_count(hc2));

   assign pos_v[0] = 32'(pos0);
   assign pos_v[1] = 32'(pos1);
   assign pos_v[2] = 32'(pos2);
   assign hc_v[0]  = 32'(hc0);
   assign hc_v[1]  = 32'(hc1);
   assign hc_v[2]  = 32'(hc2);

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         dir_v[i]   = 1'b0;
         next_v[i]  = 1'b0;
         abort_v[i] = 1'b0;
         din_v[i]   = '0;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      clear_inputs();
      cyc();
      reset = 1'b0;
   endtask

   task automatic check_idle(input int s, input string name);
      checks++;
      if (ready_v[s] !== 1'b1 || valid_v[s] !== 1'b0 || found_v[s] !== 1'b0 ||
          pos_v[s] !== 0 || hc_v[s] !== 0)
         $display("FAIL %s dut%0d: ready=%b valid=%b found=%b pos=%0d hc=%0d, want 1 0 0 0 0",
                  name, s, ready_v[s], valid_v[s], found_v[s], pos_v[s], hc_v[s]);
      else passes++;
   endtask

   // Full operation against the model: ordered logical hit list plus latency rules.
   task automatic run_op(input int s, input logic [31:0] d, input logic dr, input bit poke);
      int w, st, l, hits, idx, m, exp_m, k, ph, hold;
      int q[$];
      bit want_hit;
      w  = wv[s];
      st = sv[s];
      for (int i = 0; i < w; i++) begin
         ph = dr ? w - 1 - i : i;
         if (d[ph]) q.push_back(i);
      end
      din_v[s] = d; dir_v[s] = dr; start_v[s] = 1'b1;
      cyc();
      start_v[s] = 1'b0;
      checks++;
      if (ready_v[s] !== 1'b0) $display("FAIL busy dut%0d: ready=%b want 0", s, ready_v[s]);
      else passes++;
      if (poke) begin
         start_v[s] = 1'b1;
         din_v[s]   = ~d;
      end
      l = 0; hits = 0; idx = 0;
      forever begin
         want_hit = idx < q.size();
         if (want_hit) begin
            k     = q[idx];
            exp_m = 1 + (k - l) / st;
         end else begin
            k     = 0;
            exp_m = (w - l + st - 1) / st;
         end
         m = 0;
         while (valid_v[s] !== 1'b1 && m < exp_m + 3) begin
            cyc();
            m++;
         end
         start_v[s] = 1'b0;
         checks++;
         if (m != exp_m) begin
            $display("FAIL latency dut%0d din=%h dir=%b: %0d cycles, want %0d", s, d, dr, m, exp_m);
            pulse_reset();
            return;
         end
         passes++;
         if (want_hit) begin
            ph = dr ? w - 1 - k : k;
            checks++;
            if (found_v[s] !== 1'b1 || pos_v[s] !== ph || hc_v[s] !== hits + 1)
               $display("FAIL hit dut%0d din=%h: found=%b pos=%0d hc=%0d, want 1 %0d %0d",
                        s, d, found_v[s], pos_v[s], hc_v[s], ph, hits + 1);
            else passes++;
            hits++;
            l = k + 1;
            idx++;
            hold = $urandom_range(0, 2);
            repeat (hold) begin
               cyc();
               checks++;
               if (found_v[s] !== 1'b1 || pos_v[s] !== ph)
                  $display("FAIL hold dut%0d: found=%b pos=%0d, want 1 %0d", s, found_v[s], pos_v[s], ph);
               else passes++;
            end
            next_v[s] = 1'b1;
            cyc();
            next_v[s] = 1'b0;
         end else begin
            checks++;
            if (found_v[s] !== 1'b0 || pos_v[s] !== 0 || hc_v[s] !== hits)
               $display("FAIL done dut%0d din=%h: found=%b pos=%0d hc=%0d, want 0 0 %0d",
                        s, d, found_v[s], pos_v[s], hc_v[s], hits);
            else passes++;
            cyc();
            checks++;
            if (valid_v[s] !== 1'b0 || ready_v[s] !== 1'b1)
               $display("FAIL done_len dut%0d: valid=%b ready=%b, want 0 1", s, valid_v[s], ready_v[s]);
            else passes++;
            return;
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      for (int s = 0; s < 3; s++) check_idle(s, "reset");
   endtask

   task automatic test_directed();
      run_op(0, 32'h0000_0001, 1'b0, 1'b0);
      run_op(0, 32'h0000_0001, 1'b1, 1'b0);
      run_op(1, 32'h8000_0101, 1'b0, 1'b0);
      run_op(1, 32'h0000_0000, 1'b0, 1'b1);
      run_op(2, 32'h0000_0010, 1'b0, 1'b0);
      run_op(1, 32'hF000_000F, 1'b1, 1'b1);
   endtask

   task automatic check_aborted(input int s, input string name);
      checks++;
      if (ready_v[s] !== 1'b1 || valid_v[s] !== 1'b0 || found_v[s] !== 1'b0)
         $display("FAIL %s dut%0d: ready=%b valid=%b found=%b, want 1 0 0",
                  name, s, ready_v[s], valid_v[s], found_v[s]);
      else passes++;
      cyc();
      checks++;
      if (ready_v[s] !== 1'b1 || valid_v[s] !== 1'b0)
         $display("FAIL %s_nodone dut%0d: ready=%b valid=%b, want 1 0", s == 0 ? name : name, s,
                  ready_v[s], valid_v[s]);
      else passes++;
   endtask

   task automatic test_abort();
      din_v[1] = 32'h0010_0000; dir_v[1] = 1'b0; start_v[1] = 1'b1;
      cyc();
      start_v[1] = 1'b0;
      cyc();
      abort_v[1] = 1'b1;
      cyc();
      abort_v[1] = 1'b0;
      check_aborted(1, "abort_scan");
      for (int mode = 0; mode < 2; mode++) begin
         din_v[0] = 32'h0000_0001; dir_v[0] = 1'b0; start_v[0] = 1'b1;
         cyc();
         start_v[0] = 1'b0;
         cyc();
         checks++;
         if (found_v[0] !== 1'b1) $display("FAIL abort_pre dut0: found=%b want 1", found_v[0]);
         else passes++;
         abort_v[0] = 1'b1;
         next_v[0]  = (mode == 1);
         cyc();
         abort_v[0] = 1'b0;
         next_v[0]  = 1'b0;
         check_aborted(0, mode == 0 ? "abort_hit" : "abort_next");
      end
   endtask

   task automatic test_reset_mid();
      din_v[0] = 32'h8000_0000; dir_v[0] = 1'b0; start_v[0] = 1'b1;
      cyc();
      start_v[0] = 1'b0;
      repeat (4) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_idle(0, "reset_scan");
      din_v[0] = 32'h0000_0001; start_v[0] = 1'b1;
      cyc();
      start_v[0] = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_idle(0, "reset_hit");
   endtask

   task automatic test_random();
      int s;
      logic [31:0] d;
      for (int n = 0; n < 24; n++) begin
         s = $urandom_range(0, 2);
         d = $urandom() & $urandom() & $urandom();
         if (s == 2) d = d | 32'($urandom_range(0, 31));
         run_op(s, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
